// File: rtl/ddr_wr_pkg.sv
// Shared constants and types for the DDR line-write AXI master.
// Holds the FSM encoding, the AXI response code and the page geometry.
package ddr_wr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int         PAGE_BYTES = 4096;
    localparam int         SKID_DEPTH = 2;

    // One beat is 8*DQ_WIDTH bits, i.e. DQ_WIDTH bytes.
    function automatic int beat_bytes(input int dq_width);
        return dq_width;
    endfunction

endpackage

// File: rtl/wr_skid_fifo.sv
// Two-entry skid FIFO between the beat source and the AXI W channel.
// Push while full is legal only together with a pop (the freed slot is reused).
module wr_skid_fifo
    import ddr_wr_pkg::*;
#(
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic [1:0]    occ
);

    logic [SKID_DEPTH-1:0][DW-1:0] mem;
    logic                          wr_ptr;
    logic                          rd_ptr;
    logic [1:0]                    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign occ      = cnt;

endmodule

// File: rtl/ddr_wr_axi_master.sv
// Line-write master: splits one buffered line into AXI4 INCR bursts (max MAX_BURST
// beats, never crossing a 4 KB page), pulls beats ahead through a skid FIFO.
module ddr_wr_axi_master
    import ddr_wr_pkg::*;
#(
    parameter int ADDR_WIDTH     = 27,
    parameter int DQ_WIDTH       = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST      = 16
) (
    input  logic                      ddr_clk,
    input  logic                      ddr_rstn,
    input  logic                      ddr_wreq,
    input  logic [ADDR_WIDTH-1:0]     ddr_waddr,
    input  logic [LEN_WIDTH-1:0]      ddr_wr_len,
    output logic                      ddr_wrdy,
    input  logic [8*DQ_WIDTH-1:0]     ddr_wdata,
    output logic                      ddr_wdata_req,
    output logic                      ddr_wdone,
    output logic [AXI_ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]                awlen,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [8*DQ_WIDTH-1:0]     wdata,
    output logic [DQ_WIDTH-1:0]       wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      wr_err
);

    localparam int BW         = 8 * DQ_WIDTH;
    localparam int BEAT_BYTES = beat_bytes(DQ_WIDTH);
    localparam int WORD_BYTES = DQ_WIDTH / 8;

    localparam logic [AXI_ADDR_WIDTH-1:0] WORD_BYTES_A = AXI_ADDR_WIDTH'(WORD_BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES_A = AXI_ADDR_WIDTH'(BEAT_BYTES);
    localparam logic [12:0]               BEAT_BYTES_P = 13'(BEAT_BYTES);
    localparam logic [12:0]               PAGE_BYTES_P = 13'(PAGE_BYTES);
    localparam logic [31:0]               MAX_BURST_W  = 32'(MAX_BURST);

    wr_state_e                 state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]      line_rem;
    logic [LEN_WIDTH-1:0]      fetch_rem;
    logic [8:0]                beat_cnt;
    logic [8:0]                blen_q;
    logic                      fetch_en;
    logic                      err_q;

    logic [8:0]                blen;
    logic [8:0]                cap;
    logic [12:0]               page_bytes;
    logic [12:0]               page_beats;

    logic [1:0]                occ;
    logic [BW-1:0]             head;
    logic                      pop;
    logic                      fetch_act;

    // Burst length: min(line_rem, MAX_BURST, beats left in the 4 KB page).
    // An address less than one beat from the page end still issues one beat.
    always_comb begin
        page_bytes = PAGE_BYTES_P - {1'b0, addr_q[11:0]};
        page_beats = page_bytes / BEAT_BYTES_P;
        if (page_beats == 13'd0)
            page_beats = 13'd1;
        cap  = (32'(page_beats) < MAX_BURST_W) ? 9'(page_beats) : 9'(MAX_BURST);
        blen = (32'(line_rem) < 32'(cap)) ? 9'(line_rem) : cap;
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ddr_wrdy  = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        ddr_wdone = 1'b0;
        case (state)
            S_IDLE: begin
                ddr_wrdy = 1'b1;
                if (ddr_wreq)
                    state_nxt = S_AW;
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready)
                    state_nxt = S_W;
            end
            S_W: begin
                wvalid = (occ != 2'd0);
                if (wvalid && wready && beat_cnt == 9'd1)
                    state_nxt = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid)
                    state_nxt = (line_rem == LEN_WIDTH'(blen_q)) ? S_DONE : S_AW;
            end
            S_DONE: begin
                ddr_wdone = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pop       = wvalid & wready;
    assign fetch_act = fetch_en && (state == S_AW || state == S_W || state == S_B);
    // A pop in the same cycle frees the slot the incoming beat lands in.
    assign ddr_wdata_req = fetch_act && (fetch_rem != '0) && (occ != 2'd2 || pop);

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            addr_q    <= '0;
            line_rem  <= '0;
            fetch_rem <= '0;
            beat_cnt  <= '0;
            blen_q    <= '0;
            fetch_en  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    fetch_en <= 1'b0;
                    if (ddr_wreq) begin
                        addr_q    <= AXI_ADDR_WIDTH'(ddr_waddr) * WORD_BYTES_A;
                        line_rem  <= ddr_wr_len;
                        fetch_rem <= ddr_wr_len;
                    end
                end
                S_AW: begin
                    if (awready) begin
                        beat_cnt <= blen;
                        blen_q   <= blen;
                        fetch_en <= 1'b1;
                    end
                end
                S_W: begin
                    if (pop)
                        beat_cnt <= beat_cnt - 9'd1;
                end
                S_B: begin
                    if (bvalid) begin
                        if (bresp != RESP_OKAY)
                            err_q <= 1'b1;
                        line_rem <= line_rem - LEN_WIDTH'(blen_q);
                        addr_q   <= addr_q + AXI_ADDR_WIDTH'(blen_q) * BEAT_BYTES_A;
                    end
                end
                default: ;
            endcase
            if (ddr_wdata_req)
                fetch_rem <= fetch_rem - LEN_WIDTH'(1);
        end
    end

    wr_skid_fifo #(
        .DW (BW)
    ) u_skid (
        .clk       (ddr_clk),
        .rst_n     (ddr_rstn),
        .push      (ddr_wdata_req),
        .push_data (ddr_wdata),
        .pop       (pop),
        .pop_data  (head),
        .occ       (occ)
    );

    assign awaddr = addr_q;
    assign awlen  = (state == S_AW) ? 8'(blen - 9'd1) : 8'd0;
    assign wdata  = head;
    assign wstrb  = wvalid ? '1 : '0;
    assign wlast  = wvalid && (beat_cnt == 9'd1);
    assign wr_err = err_q;

endmodule

// File: tb/tb_ddr_wr_axi_master.sv
// Scoreboard bench for ddr_wr_axi_master: expected bursts and beats are queued
// when a line is issued or a beat is pulled, and checked at each AXI handshake.
module tb_ddr_wr_axi_master;

    logic         ddr_clk;
    logic         ddr_rstn;
    logic         ddr_wreq;
    logic [26:0]  ddr_waddr;
    logic [15:0]  ddr_wr_len;
    logic         ddr_wrdy;
    logic [255:0] ddr_wdata;
    logic         ddr_wdata_req;
    logic         ddr_wdone;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         awvalid;
    logic         awready;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic         wr_err;

    ddr_wr_axi_master dut (
        .ddr_clk       (ddr_clk),
        .ddr_rstn      (ddr_rstn),
        .ddr_wreq      (ddr_wreq),
        .ddr_waddr     (ddr_waddr),
        .ddr_wr_len    (ddr_wr_len),
        .ddr_wrdy      (ddr_wrdy),
        .ddr_wdata     (ddr_wdata),
        .ddr_wdata_req (ddr_wdata_req),
        .ddr_wdone     (ddr_wdone),
        .awaddr        (awaddr),
        .awlen         (awlen),
        .awvalid       (awvalid),
        .awready       (awready),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wlast         (wlast),
        .wvalid        (wvalid),
        .wready        (wready),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready),
        .wr_err        (wr_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    aw_t          exp_aw[$];
    logic [255:0] exp_w[$];
    int           wq[$];

    int checks = 0;
    int failures = 0;
    int req_cnt, done_cnt, b_cnt, w_hs, occ_tb, bi, occ_viol, wrdy_viol;
    bit stall, err_mode, adv_pending;

    initial begin
        ddr_clk = 1'b0;
        forever #5 ddr_clk = ~ddr_clk;
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference burst split: min(remaining, 16, beats to the next 4 KB page).
    task automatic model_line(input logic [31:0] a0, input int len);
        logic [31:0] a;
        int rem, page, b;
        a = a0;
        rem = len;
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / 32;
            if (page == 0) page = 1;
            b = (rem < 16) ? rem : 16;
            if (page < b) b = page;
            exp_aw.push_back('{a, 8'(b - 1)});
            wq.push_back(b);
            a = a + 32'(b * 32);
            rem = rem - b;
        end
    endtask

    // AXI slave / beat source / monitor. Inputs change at negedge, sampling at negedge+1.
    initial begin
        logic  pop_s, req_s;
        aw_t   e;
        logic [255:0] ed;
        logic  exp_last;
        forever begin
            @(negedge ddr_clk);
            if (adv_pending) begin
                ddr_wdata = rnd256();
                adv_pending = 1'b0;
            end
            wready  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            awready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            bvalid  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            bresp   = (err_mode && b_cnt == 1) ? 2'b10 : 2'b00;
            #1;
            if (ddr_rstn) begin
                pop_s = wvalid && wready;
                req_s = ddr_wdata_req;
                if (ddr_wrdy && (awvalid || wvalid || bready || ddr_wdone || req_s))
                    wrdy_viol++;
                if (awvalid && awready) begin
                    checks++;
                    if (exp_aw.size() == 0) begin
                        failures++;
                        $display("FAIL aw_unexpected got addr=%h len=%0d", awaddr, awlen);
                    end else begin
                        e = exp_aw.pop_front();
                        if (awaddr !== e.addr || awlen !== e.len) begin
                            failures++;
                            $display("FAIL aw_burst got addr=%h len=%0d exp addr=%h len=%0d",
                                     awaddr, awlen, e.addr, e.len);
                        end
                    end
                end
                if (pop_s) begin
                    w_hs++;
                    checks++;
                    if (exp_w.size() == 0 || wq.size() == 0) begin
                        failures++;
                        $display("FAIL w_unexpected beat with empty scoreboard");
                    end else begin
                        ed = exp_w.pop_front();
                        exp_last = (bi + 1 == wq[0]);
                        if (wdata !== ed || wlast !== exp_last || wstrb !== 32'hFFFF_FFFF) begin
                            failures++;
                            $display("FAIL w_beat got data=%h last=%b strb=%h exp data=%h last=%b",
                                     wdata, wlast, wstrb, ed, exp_last);
                        end
                        bi++;
                        if (exp_last) begin
                            bi = 0;
                            void'(wq.pop_front());
                        end
                    end
                end
                if (bvalid && bready) b_cnt++;
                if (ddr_wdone) done_cnt++;
                if (req_s) begin
                    if (occ_tb == 2 && !pop_s) occ_viol++;
                    exp_w.push_back(ddr_wdata);
                    req_cnt++;
                    adv_pending = 1'b1;
                    ddr_wreq = 1'b0;
                end
                occ_tb = occ_tb + (req_s ? 1 : 0) - (pop_s ? 1 : 0);
            end
        end
    end

    task automatic clear_counts();
        req_cnt = 0; done_cnt = 0; b_cnt = 0; w_hs = 0; occ_viol = 0; wrdy_viol = 0;
    endtask

    task automatic start_line(input logic [26:0] wa, input int len);
        @(negedge ddr_clk);
        ddr_waddr  = wa;
        ddr_wr_len = 16'(len);
        ddr_wreq   = 1'b1;
        model_line({3'b000, wa, 2'b00}, len);
    endtask

    task automatic wait_done(input string nm, input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge ddr_clk); #2;
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL %s_timeout got done=%0d exp done=%0d", nm, done_cnt, target);
        end
    endtask

    task automatic end_checks(input string nm, input int exp_req, input int exp_done);
        repeat (4) @(negedge ddr_clk);
        #2;
        checks++;
        if (req_cnt !== exp_req) begin
            failures++;
            $display("FAIL %s_req_count got %0d exp %0d", nm, req_cnt, exp_req);
        end
        checks++;
        if (done_cnt !== exp_done) begin
            failures++;
            $display("FAIL %s_done_pulses got %0d exp %0d", nm, done_cnt, exp_done);
        end
        checks++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            failures++;
            $display("FAIL %s_scoreboard_left got aw=%0d w=%0d exp 0/0", nm, exp_aw.size(), exp_w.size());
        end
        checks++;
        if (occ_viol != 0 || wrdy_viol != 0) begin
            failures++;
            $display("FAIL %s_protocol got occ_viol=%0d wrdy_viol=%0d exp 0/0", nm, occ_viol, wrdy_viol);
        end
        checks++;
        if (ddr_wrdy !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle_wrdy got %b exp 1", nm, ddr_wrdy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ddr_clk);
        #2;
        checks++;
        if ({ddr_wrdy, awvalid, wvalid, wlast, bready, ddr_wdata_req, ddr_wdone, wr_err} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_ctrl got %b exp 10000000",
                     {ddr_wrdy, awvalid, wvalid, wlast, bready, ddr_wdata_req, ddr_wdone, wr_err});
        end
        checks++;
        if (awaddr !== 32'h0 || awlen !== 8'h0 || wstrb !== 32'h0 || wdata !== 256'h0) begin
            failures++;
            $display("FAIL reset_bus got awaddr=%h awlen=%h wstrb=%h exp 0", awaddr, awlen, wstrb);
        end
        ddr_rstn = 1'b1;
        @(negedge ddr_clk); #2;
        checks++;
        if (ddr_wrdy !== 1'b1 || awvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got wrdy=%b awvalid=%b exp 1/0", ddr_wrdy, awvalid);
        end
    endtask

    task automatic test_basic();
        clear_counts();
        stall = 0;
        start_line(27'h0, 30);
        wait_done("basic", 1);
        end_checks("basic", 30, 1);
    endtask

    task automatic test_stalls();
        clear_counts();
        stall = 1;
        start_line(27'h1000, 20);
        wait_done("stall", 1);
        end_checks("stall", 20, 1);
        stall = 0;
    endtask

    task automatic test_page_cross();
        clear_counts();
        start_line(27'h3E0, 16);
        wait_done("page", 1);
        end_checks("page", 16, 1);
    endtask

    task automatic test_bresp_err();
        clear_counts();
        checks++;
        if (wr_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clean_before got %b exp 0", wr_err);
        end
        err_mode = 1;
        start_line(27'h40, 30);
        wait_done("err", 1);
        err_mode = 0;
        end_checks("err", 30, 1);
        checks++;
        if (wr_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got %b exp 1", wr_err);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        start_line(27'h200, 18);
        wait_done("b2b_first", 1);
        start_line(27'h5000, 5);
        wait_done("b2b_second", 2);
        end_checks("b2b", 23, 2);
        checks++;
        if (wr_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got %b exp 1", wr_err);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        clear_counts();
        stall = 1;
        start_line(27'h100, 40);
        while (w_hs < 5 && n < 2000) begin
            @(negedge ddr_clk); #2;
            n++;
        end
        checks++;
        if (w_hs < 5) begin
            failures++;
            $display("FAIL midrst_reach_w got beats=%0d exp >=5", w_hs);
        end
        @(negedge ddr_clk); #3;
        ddr_rstn = 1'b0;
        #1;
        checks++;
        if ({ddr_wrdy, awvalid, wvalid, wlast, bready, ddr_wdata_req, ddr_wdone, wr_err} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL midrst_async got %b exp 10000000",
                     {ddr_wrdy, awvalid, wvalid, wlast, bready, ddr_wdata_req, ddr_wdone, wr_err});
        end
        checks++;
        if (awaddr !== 32'h0 || awlen !== 8'h0 || wstrb !== 32'h0) begin
            failures++;
            $display("FAIL midrst_bus got awaddr=%h awlen=%h wstrb=%h exp 0", awaddr, awlen, wstrb);
        end
        ddr_wreq = 1'b0;
        exp_aw.delete();
        exp_w.delete();
        wq.delete();
        bi = 0;
        occ_tb = 0;
        adv_pending = 1'b0;
        stall = 0;
        repeat (3) @(negedge ddr_clk);
        ddr_rstn = 1'b1;
        clear_counts();
        start_line(27'h7F0, 12);
        wait_done("postrst", 1);
        end_checks("postrst", 12, 1);
    endtask

    initial begin
        ddr_rstn   = 1'b0;
        ddr_wreq   = 1'b0;
        ddr_waddr  = '0;
        ddr_wr_len = '0;
        ddr_wdata  = rnd256();
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bresp      = 2'b00;
        stall = 0; err_mode = 0; adv_pending = 0;
        occ_tb = 0; bi = 0;
        clear_counts();
        test_reset();
        test_basic();
        test_stalls();
        test_page_cross();
        test_bresp_err();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
